// File: rtl/alu_param_seq.sv
// Parametrised sequential ALU: split operand collection with timeout, multi-cycle multiply, registered results.
// Latency: single-cycle ops 1 cycle after accept; multiplies MUL_LAT cycles; timeout error TIMEOUT+1 cycles after first operand.
// Backpressure: BUSY high while a multiply is in flight, inputs ignored then; CE=0 freezes all state.
module alu_param_seq #(
    parameter int W       = 8,
    parameter int TIMEOUT = 16,
    parameter int MUL_LAT = 3
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           CE,
    input  logic           MODE,
    input  logic [3:0]     CMD,
    input  logic [1:0]     INP_VALID,
    input  logic [W-1:0]   OPA,
    input  logic [W-1:0]   OPB,
    input  logic           CIN,
    output logic [2*W-1:0] RES,
    output logic           RES_VALID,
    output logic           COUT,
    output logic           OFLOW,
    output logic           G,
    output logic           L,
    output logic           E,
    output logic           ERR,
    output logic           BUSY
);

    localparam int LW      = $clog2(W);
    localparam int CNT_MAX = (TIMEOUT > MUL_LAT) ? TIMEOUT : MUL_LAT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LAT - 1);
    localparam logic [W:0]    ONE1     = (W+1)'(1);

    typedef enum logic [1:0] {IDLE, WAIT_OPND, EXEC_MUL} state_t;

    typedef struct packed {
        logic [2*W-1:0] res;
        logic           cout;
        logic           oflow;
        logic           g;
        logic           l;
        logic           e;
        logic           err;
    } alu_out_t;

    function automatic logic cmd_ok(input logic mode, input logic [3:0] cmd);
        return mode ? (cmd <= 4'd12) : (cmd <= 4'd13);
    endfunction

    // 01 = A only, 10 = B only, 11 = both
    function automatic logic [1:0] cmd_need(input logic mode, input logic [3:0] cmd);
        logic [1:0] n;
        n = 2'b11;
        if (mode) begin
            if (cmd == 4'd4 || cmd == 4'd5) n = 2'b01;
            if (cmd == 4'd6 || cmd == 4'd7) n = 2'b10;
        end else begin
            if (cmd == 4'd6 || cmd == 4'd8 || cmd == 4'd9)   n = 2'b01;
            if (cmd == 4'd7 || cmd == 4'd10 || cmd == 4'd11) n = 2'b10;
        end
        return n;
    endfunction

    function automatic logic cmd_is_mul(input logic mode, input logic [3:0] cmd);
        return mode && (cmd == 4'd9 || cmd == 4'd10);
    endfunction

    function automatic logic [2*W-1:0] zx(input logic [W-1:0] v);
        return {{W{1'b0}}, v};
    endfunction

    function automatic alu_out_t alu_eval(input logic mode, input logic [3:0] cmd,
                                          input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin);
        alu_out_t         r;
        logic [W:0]       s;
        logic [W:0]       a1;
        logic [W:0]       b1;
        logic [W-1:0]     q;
        logic [2*W-1:0]   t;
        logic [2*W+1:0]   p;
        r  = '0;
        s  = '0;
        q  = '0;
        t  = '0;
        a1 = {1'b0, a} + ONE1;
        b1 = {1'b0, b} + ONE1;
        p  = '0;
        if (mode) begin
            case (cmd)
                4'd0:  begin s = {1'b0, a} + {1'b0, b}; r.res = {{(W-1){1'b0}}, s}; r.cout = s[W]; end
                4'd1:  begin s = {1'b0, a} - {1'b0, b}; r.res = zx(s[W-1:0]); r.oflow = s[W]; end
                4'd2:  begin
                    s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                    r.res = {{(W-1){1'b0}}, s}; r.cout = s[W];
                end
                4'd3:  begin
                    s = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin};
                    r.res = zx(s[W-1:0]); r.oflow = s[W];
                end
                4'd4:  begin s = {1'b0, a} + ONE1; r.res = {{(W-1){1'b0}}, s}; r.cout = s[W]; end
                4'd5:  begin s = {1'b0, a} - ONE1; r.res = zx(s[W-1:0]); r.oflow = s[W]; end
                4'd6:  begin s = {1'b0, b} + ONE1; r.res = {{(W-1){1'b0}}, s}; r.cout = s[W]; end
                4'd7:  begin s = {1'b0, b} - ONE1; r.res = zx(s[W-1:0]); r.oflow = s[W]; end
                4'd8:  begin r.g = (a > b); r.l = (a < b); r.e = (a == b); end
                4'd9:  begin
                    // (2^W)*(2^W) does not fit 2W bits; the top product bit is dropped
                    p = {{(W+1){1'b0}}, a1} * {{(W+1){1'b0}}, b1};
                    r.res = p[2*W-1:0];
                end
                4'd10: begin q = a << 1; t = zx(q) * zx(b); r.res = t; end
                4'd11: begin
                    q = a + b;
                    r.res = {{W{q[W-1]}}, q};
                    r.oflow = (a[W-1] == b[W-1]) && (q[W-1] != a[W-1]);
                end
                4'd12: begin
                    q = a - b;
                    r.res = {{W{q[W-1]}}, q};
                    r.oflow = (a[W-1] != b[W-1]) && (q[W-1] != a[W-1]);
                end
                default: r.err = 1'b1;
            endcase
        end else begin
            case (cmd)
                4'd0:  r.res = zx(a & b);
                4'd1:  r.res = zx(~(a & b));
                4'd2:  r.res = zx(a | b);
                4'd3:  r.res = zx(~(a | b));
                4'd4:  r.res = zx(a ^ b);
                4'd5:  r.res = zx(~(a ^ b));
                4'd6:  r.res = zx(~a);
                4'd7:  r.res = zx(~b);
                4'd8:  r.res = zx(a >> 1);
                4'd9:  r.res = zx(a << 1);
                4'd10: r.res = zx(b >> 1);
                4'd11: r.res = zx(b << 1);
                4'd12, 4'd13: begin
                    // rotate amount beyond W-1 is rejected rather than wrapped
                    if (|b[W-1:LW]) begin
                        r.err = 1'b1;
                    end else if (cmd == 4'd12) begin
                        t = {a, a} << b[LW-1:0];
                        r.res = zx(t[2*W-1:W]);
                    end else begin
                        t = {a, a} >> b[LW-1:0];
                        r.res = zx(t[W-1:0]);
                    end
                end
                default: r.err = 1'b1;
            endcase
        end
        return r;
    endfunction

    state_t         state, state_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [3:0]     h_cmd, h_cmd_n;
    logic           h_mode, h_mode_n;
    logic           h_cin, h_cin_n;
    logic           h_has_a, h_has_a_n;
    logic [W-1:0]   h_opnd, h_opnd_n;
    logic [2*W-1:0] mul_res, mul_res_n;
    alu_out_t       out_n;
    logic           rv_n;
    logic           busy_n;

    logic [1:0]     need;
    logic           w_arrived;
    logic [W-1:0]   w_a, w_b;
    alu_out_t       eval_idle, eval_wait;

    assign need      = cmd_need(MODE, CMD);
    assign eval_idle = alu_eval(MODE, CMD, OPA, OPB, CIN);
    assign w_a       = h_has_a ? h_opnd : OPA;
    assign w_b       = h_has_a ? OPB : h_opnd;
    assign w_arrived = h_has_a ? INP_VALID[1] : INP_VALID[0];
    assign eval_wait = alu_eval(h_mode, h_cmd, w_a, w_b, h_cin);

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        h_cmd_n   = h_cmd;
        h_mode_n  = h_mode;
        h_cin_n   = h_cin;
        h_has_a_n = h_has_a;
        h_opnd_n  = h_opnd;
        mul_res_n = mul_res;
        out_n     = {RES, COUT, OFLOW, G, L, E, ERR};
        rv_n      = 1'b0;
        busy_n    = BUSY;
        case (state)
            IDLE: begin
                if (INP_VALID != 2'b00) begin
                    if (!cmd_ok(MODE, CMD)) begin
                        out_n     = '0;
                        out_n.err = 1'b1;
                        rv_n      = 1'b1;
                    end else if ((INP_VALID & need) == need) begin
                        if (cmd_is_mul(MODE, CMD)) begin
                            mul_res_n = eval_idle.res;
                            busy_n    = 1'b1;
                            cnt_n     = CW'(1);
                            state_n   = EXEC_MUL;
                        end else begin
                            out_n = eval_idle;
                            rv_n  = 1'b1;
                        end
                    end else if (need == 2'b11) begin
                        h_cmd_n   = CMD;
                        h_mode_n  = MODE;
                        h_cin_n   = CIN;
                        h_has_a_n = INP_VALID[0];
                        h_opnd_n  = INP_VALID[0] ? OPA : OPB;
                        cnt_n     = '0;
                        state_n   = WAIT_OPND;
                    end else begin
                        out_n     = '0;
                        out_n.err = 1'b1;
                        rv_n      = 1'b1;
                    end
                end
            end
            WAIT_OPND: begin
                if (w_arrived) begin
                    if (cmd_is_mul(h_mode, h_cmd)) begin
                        mul_res_n = eval_wait.res;
                        busy_n    = 1'b1;
                        cnt_n     = CW'(1);
                        state_n   = EXEC_MUL;
                    end else begin
                        out_n   = eval_wait;
                        rv_n    = 1'b1;
                        state_n = IDLE;
                    end
                end else if (cnt == TO_LAST) begin
                    out_n     = '0;
                    out_n.err = 1'b1;
                    rv_n      = 1'b1;
                    state_n   = IDLE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            EXEC_MUL: begin
                if (cnt == MUL_LAST) begin
                    out_n     = '0;
                    out_n.res = mul_res;
                    rv_n      = 1'b1;
                    busy_n    = 1'b0;
                    state_n   = IDLE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            h_cmd     <= '0;
            h_mode    <= 1'b0;
            h_cin     <= 1'b0;
            h_has_a   <= 1'b0;
            h_opnd    <= '0;
            mul_res   <= '0;
            RES       <= '0;
            COUT      <= 1'b0;
            OFLOW     <= 1'b0;
            G         <= 1'b0;
            L         <= 1'b0;
            E         <= 1'b0;
            ERR       <= 1'b0;
            RES_VALID <= 1'b0;
            BUSY      <= 1'b0;
        end else if (CE) begin
            state     <= state_n;
            cnt       <= cnt_n;
            h_cmd     <= h_cmd_n;
            h_mode    <= h_mode_n;
            h_cin     <= h_cin_n;
            h_has_a   <= h_has_a_n;
            h_opnd    <= h_opnd_n;
            mul_res   <= mul_res_n;
            {RES, COUT, OFLOW, G, L, E, ERR} <= out_n;
            RES_VALID <= rv_n;
            BUSY      <= busy_n;
        end else begin
            RES_VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_param_seq.sv
// Scoreboard bench for alu_param_seq: stimulus pushes expected results, a negedge monitor pops and compares.
module tb_alu_param_seq;
    localparam int W       = 8;
    localparam int TIMEOUT = 16;
    localparam int MUL_LAT = 3;

    logic           CLK = 1'b0;
    logic           RST, CE, MODE, CIN;
    logic [3:0]     CMD;
    logic [1:0]     INP_VALID;
    logic [W-1:0]   OPA, OPB;
    logic [2*W-1:0] RES;
    logic           RES_VALID, COUT, OFLOW, G, L, E, ERR, BUSY;

    always #5 CLK = ~CLK;

    alu_param_seq #(.W(W), .TIMEOUT(TIMEOUT), .MUL_LAT(MUL_LAT)) dut (
        .CLK(CLK), .RST(RST), .CE(CE), .MODE(MODE), .CMD(CMD), .INP_VALID(INP_VALID),
        .OPA(OPA), .OPB(OPB), .CIN(CIN), .RES(RES), .RES_VALID(RES_VALID),
        .COUT(COUT), .OFLOW(OFLOW), .G(G), .L(L), .E(E), .ERR(ERR), .BUSY(BUSY)
    );

    typedef struct packed {
        logic [2*W-1:0] res;
        logic cout, oflow, g, l, e, err;
    } res_t;

    typedef struct packed {
        res_t        r;
        logic [31:0] cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          passes = 0;
    int unsigned cyc = 0;   // clock edges with CE=1
    bit          stall_en = 1'b0;

    always @(posedge CLK) if (CE) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    always @(negedge CLK) begin
        if (RES_VALID === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_res_valid: got RES_VALID=1 RES=0x%0h at cycle %0d, required no result",
                         RES, cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("result", {RES, COUT, OFLOW, G, L, E, ERR}, e.r);
                check("latency", cyc, e.cyc);
            end
        end
    end

    function automatic logic [1:0] tb_need(input bit mode, input int cmd);
        if (mode) begin
            if (cmd == 4 || cmd == 5) return 2'b01;
            if (cmd == 6 || cmd == 7) return 2'b10;
        end else begin
            if (cmd == 6 || cmd == 8 || cmd == 9)   return 2'b01;
            if (cmd == 7 || cmd == 10 || cmd == 11) return 2'b10;
        end
        return 2'b11;
    endfunction

    function automatic bit tb_valid(input bit mode, input int cmd);
        return mode ? (cmd <= 12) : (cmd <= 13);
    endfunction

    function automatic bit tb_is_mul(input bit mode, input int cmd);
        return mode && (cmd == 9 || cmd == 10);
    endfunction

    function automatic res_t err_res();
        res_t x;
        x = '0;
        x.err = 1'b1;
        return x;
    endfunction

    // Reference behaviour in plain integer arithmetic
    function automatic res_t model(input bit mode, input int cmd, input int a, input int b, input bit cin);
        res_t x;
        int m, h, r, sa, sb, s, n;
        m = 1 << W; h = m / 2; r = 0; x = '0;
        sa = (a >= h) ? a - m : a;
        sb = (b >= h) ? b - m : b;
        if (mode) begin
            case (cmd)
                0:  begin r = a + b; x.cout = (r >= m); end
                1:  begin r = (a - b) & (m - 1); x.oflow = (a < b); end
                2:  begin r = a + b + int'(cin); x.cout = (r >= m); end
                3:  begin r = (a - b - int'(cin)) & (m - 1); x.oflow = (a < b + int'(cin)); end
                4:  begin r = a + 1; x.cout = (r >= m); end
                5:  begin r = (a - 1) & (m - 1); x.oflow = (a == 0); end
                6:  begin r = b + 1; x.cout = (r >= m); end
                7:  begin r = (b - 1) & (m - 1); x.oflow = (b == 0); end
                8:  begin x.g = (a > b); x.l = (a < b); x.e = (a == b); end
                9:  r = ((a + 1) * (b + 1)) % (m * m);
                10: r = ((2 * a) % m) * b;
                11, 12: begin
                    s = (cmd == 11) ? sa + sb : sa - sb;
                    x.oflow = (s >= h) || (s < -h);
                    r = s & (m - 1);
                    if (r >= h) r = r + m * m - m;
                end
                default: x.err = 1'b1;
            endcase
        end else begin
            case (cmd)
                0:  r = a & b;
                1:  r = ~(a & b) & (m - 1);
                2:  r = a | b;
                3:  r = ~(a | b) & (m - 1);
                4:  r = a ^ b;
                5:  r = ~(a ^ b) & (m - 1);
                6:  r = ~a & (m - 1);
                7:  r = ~b & (m - 1);
                8:  r = a / 2;
                9:  r = (a * 2) % m;
                10: r = b / 2;
                11: r = (b * 2) % m;
                12, 13: begin
                    if (b >= W) x.err = 1'b1;
                    else begin
                        n = b;
                        if (cmd == 12) r = ((a << n) | (a >> (W - n))) & (m - 1);
                        else           r = ((a >> n) | (a << (W - n))) & (m - 1);
                    end
                end
                default: x.err = 1'b1;
            endcase
        end
        x.res = (2*W)'(r);
        return x;
    endfunction

    task automatic push(input res_t r, input int unsigned at);
        exp_t e;
        e.r = r;
        e.cyc = at;
        sb_q.push_back(e);
    endtask

    task automatic rand_inputs();
        MODE      = 1'($urandom);
        CMD       = 4'($urandom);
        INP_VALID = 2'($urandom);
        OPA       = W'($urandom);
        OPB       = W'($urandom);
        CIN       = 1'($urandom);
    endtask

    task automatic stall(input int n);
        CE = 1'b0;
        repeat (n) begin
            rand_inputs();
            @(posedge CLK); #1;
        end
        CE = 1'b1;
    endtask

    task automatic step(input bit rst = 1'b0);
        logic m, c;
        logic [3:0] cm;
        logic [1:0] iv;
        logic [W-1:0] a, b;
        if (stall_en && $urandom_range(0, 5) == 0) begin
            m = MODE; c = CIN; cm = CMD; iv = INP_VALID; a = OPA; b = OPB;
            stall($urandom_range(1, 2));
            MODE = m; CIN = c; CMD = cm; INP_VALID = iv; OPA = a; OPB = b;
        end
        RST = rst;
        CE  = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    task automatic idle();
        rand_inputs();
        INP_VALID = 2'b00;
        step();
    endtask

    // Busy window after a multiply accept; an ADD is driven in its first cycle
    task automatic run_busy();
        check("busy_after_accept", BUSY, 1);
        for (int i = 1; i < MUL_LAT; i++) begin
            rand_inputs();
            if (i == 1) begin MODE = 1'b1; CMD = 4'd0; INP_VALID = 2'b11; end
            step();
            if (i == MUL_LAT - 1) check("busy_drop", BUSY, 0);
            else                  check("busy_high", BUSY, 1);
        end
    endtask

    task automatic issue(input bit mode, input int cmd, input logic [1:0] iv,
                         input int a, input int b, input bit cin);
        logic [1:0] need;
        res_t r;
        MODE = mode; CMD = 4'(cmd); INP_VALID = iv; OPA = W'(a); OPB = W'(b); CIN = cin;
        step();
        need = tb_need(mode, cmd);
        if (!tb_valid(mode, cmd)) push(err_res(), cyc);
        else if ((iv & need) == need) begin
            r = model(mode, cmd, a, b, cin);
            if (tb_is_mul(mode, cmd)) begin
                push(r, cyc + MUL_LAT - 1);
                run_busy();
            end else push(r, cyc);
        end else push(err_res(), cyc);
    endtask

    // First operand alone, missing one arrives on wait cycle k (k > TIMEOUT: never)
    task automatic split(input bit mode, input int cmd, input int a, input int b, input bit cin,
                         input bit first_a, input int k, input int stall_at);
        int unsigned e0;
        res_t r;
        bit done;
        done = 1'b0;
        MODE = mode; CMD = 4'(cmd); CIN = cin;
        INP_VALID = first_a ? 2'b01 : 2'b10;
        OPA = first_a ? W'(a) : W'($urandom);
        OPB = first_a ? W'($urandom) : W'(b);
        step();
        e0 = cyc;
        for (int i = 1; i <= TIMEOUT && !done; i++) begin
            if (i == stall_at) stall(5);
            rand_inputs();
            if (first_a) begin
                INP_VALID[1] = (i == k);
                if (i == k) OPB = W'(b);
            end else begin
                INP_VALID[0] = (i == k);
                if (i == k) OPA = W'(a);
            end
            step();
            if (i == k) begin
                done = 1'b1;
                r = model(mode, cmd, a, b, cin);
                if (tb_is_mul(mode, cmd)) begin
                    push(r, e0 + k + MUL_LAT - 1);
                    run_busy();
                end else push(r, e0 + k);
            end
        end
        if (!done) push(err_res(), e0 + TIMEOUT);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        int kind, cmd, a, b;
        bit mode, cin;
        logic [1:0] iv;

        RST = 1'b1; CE = 1'b1; MODE = 1'b0; CMD = '0; INP_VALID = '0; OPA = '0; OPB = '0; CIN = 1'b0;
        step(1'b1);
        step(1'b1);
        check("reset_outputs", {RES, RES_VALID, COUT, OFLOW, G, L, E, ERR, BUSY}, 0);

        issue(1'b1, 0, 2'b11, 200, 100, 1'b0);
        repeat (3) idle();
        check("res_hold", {RES, COUT, RES_VALID}, {16'h012C, 1'b1, 1'b0});

        issue(1'b1, 9, 2'b11, 3, 4, 1'b0);
        split(1'b1, 0, 10, 7, 1'b0, 1'b1, 5, 0);
        idle();
        split(1'b1, 0, 10, 7, 1'b0, 1'b1, TIMEOUT + 1, 0);
        issue(1'b0, 12, 2'b11, 8'h81, 1, 1'b0);
        issue(1'b0, 12, 2'b11, 8'h81, 8'h09, 1'b0);
        issue(1'b0, 13, 2'b11, 8'h81, 3, 1'b0);
        issue(1'b1, 11, 2'b11, 100, 100, 1'b0);
        issue(1'b1, 12, 2'b11, 8'h80, 1, 1'b0);
        issue(1'b1, 8, 2'b11, 5, 5, 1'b0);
        issue(1'b1, 4, 2'b10, 7, 9, 1'b0);
        issue(1'b0, 14, 2'b11, 1, 2, 1'b0);
        split(1'b1, 10, 5, 6, 1'b0, 1'b0, 2, 0);

        // Reset in the first busy cycle must drop the multiply silently
        MODE = 1'b1; CMD = 4'd9; INP_VALID = 2'b11; OPA = 8'd3; OPB = 8'd4;
        step();
        check("busy_before_reset", BUSY, 1);
        rand_inputs();
        step(1'b1);
        check("reset_mid_mul", {RES, RES_VALID, COUT, OFLOW, G, L, E, ERR, BUSY}, 0);
        repeat (MUL_LAT + 2) idle();

        split(1'b1, 0, 1, 2, 1'b1, 1'b1, TIMEOUT + 1, 4);
        idle();

        stall_en = 1'b1;
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 9);
            mode = 1'($urandom);
            cmd  = $urandom_range(0, 15);
            a    = $urandom_range(0, (1 << W) - 1);
            b    = $urandom_range(0, (1 << W) - 1);
            cin  = 1'($urandom);
            if (!mode && (cmd == 12 || cmd == 13) && $urandom_range(0, 3) != 0)
                b = $urandom_range(0, W + 2);
            if (kind < 7 || !tb_valid(mode, cmd) || tb_need(mode, cmd) != 2'b11) begin
                if (!tb_valid(mode, cmd) || tb_need(mode, cmd) == 2'b11) iv = 2'b11;
                else iv = 2'($urandom_range(1, 3));
                issue(mode, cmd, iv, a, b, cin);
            end else begin
                split(mode, cmd, a, b, cin, 1'($urandom),
                      ($urandom_range(0, 7) == 0) ? TIMEOUT + 1 : $urandom_range(1, TIMEOUT), 0);
            end
            repeat ($urandom_range(0, 2)) idle();
        end

        stall_en = 1'b0;
        repeat (MUL_LAT + 2) idle();
        check("pending_results", sb_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
